// File: rtl/ps2_note_keys.sv
// PS/2 scancode decoder: parses make/break/extended sequences from the
// PS2_Controller byte stream and maps configured make codes onto note channels,
// producing a held/toggled state vector and one-cycle press/release events.
module ps2_note_keys #(
    parameter int unsigned                NUM_KEYS       = 8,
    parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = 64'h423B33342B231B1C,
    parameter bit                         TOGGLE_MODE    = 1'b0,
    parameter int unsigned                TIMEOUT_CYCLES = 2500000,
    localparam int unsigned               IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [7:0]            received_data,
    input  logic                  received_data_en,
    output logic [NUM_KEYS-1:0]   key_state,
    output logic                  any_held,
    output logic                  event_valid,
    output logic [IDX_W-1:0]      event_key,
    output logic                  event_press,
    output logic                  event_ext,
    output logic [7:0]            last_code
);

    localparam int unsigned TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]  CODE_EXT = 8'hE0;
    localparam logic [7:0]  CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_nxt;

    logic                  w_complete;
    logic                  w_is_brk;
    logic                  w_is_ext;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_press;
    logic                  w_release;
    logic [NUM_KEYS-1:0]   w_onehot;
    logic [NUM_KEYS-1:0]   w_hold_nxt;
    logic [NUM_KEYS-1:0]   w_key_state_nxt;

    logic [NUM_KEYS-1:0]   r_hold;
    logic [NUM_KEYS-1:0]   r_key_state;
    logic                  r_any_held;
    logic                  r_event_valid;
    logic [IDX_W-1:0]      r_event_key;
    logic                  r_event_press;
    logic                  r_event_ext;
    logic [7:0]            r_last_code;

    // Sequence state and prefix timeout counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state decode: prefix tracking, completion detection, timeout abort
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_complete  = 1'b0;
        w_is_brk    = 1'b0;
        w_is_ext    = 1'b0;
        if (received_data_en) begin
            w_timer_nxt = '0;
            case (r_state)
                IDLE: begin
                    if (received_data == CODE_EXT)      w_state_nxt = EXT;
                    else if (received_data == CODE_BRK) w_state_nxt = BRK;
                    else                                w_complete  = 1'b1;
                end
                EXT: begin
                    if (received_data == CODE_BRK)      w_state_nxt = EXT_BRK;
                    else if (received_data == CODE_EXT) w_state_nxt = EXT;
                    else begin
                        w_complete = 1'b1;
                        w_is_ext   = 1'b1;
                    end
                end
                BRK: begin
                    if (received_data == CODE_BRK)      w_state_nxt = BRK;
                    else if (received_data == CODE_EXT) w_state_nxt = EXT;
                    else begin
                        w_complete = 1'b1;
                        w_is_brk   = 1'b1;
                    end
                end
                EXT_BRK: begin
                    if (received_data == CODE_BRK)      w_state_nxt = BRK;
                    else if (received_data == CODE_EXT) w_state_nxt = EXT;
                    else begin
                        w_complete = 1'b1;
                        w_is_brk   = 1'b1;
                        w_is_ext   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            if (w_complete) w_state_nxt = IDLE;
        end else if (r_state != IDLE) begin
            if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = r_timer + TMR_W'(1);
            end
        end
    end

    // Scancode lookup: lowest channel whose configured code matches the byte
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!w_hit && (KEY_CODES[8*i +: 8] == received_data)) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    // Event acceptance with typematic suppression, and next channel state
    always_comb begin
        w_press         = w_complete && !w_is_ext && !w_is_brk && w_hit && !r_hold[w_idx];
        w_release       = w_complete && !w_is_ext &&  w_is_brk && w_hit &&  r_hold[w_idx];
        w_onehot        = NUM_KEYS'(1) << w_idx;
        w_hold_nxt      = r_hold;
        w_key_state_nxt = r_key_state;
        if (w_press)   w_hold_nxt = r_hold | w_onehot;
        if (w_release) w_hold_nxt = r_hold & ~w_onehot;
        if (TOGGLE_MODE) begin
            if (w_press) w_key_state_nxt = r_key_state ^ w_onehot;
        end else begin
            w_key_state_nxt = w_hold_nxt;
        end
    end

    // Registered channel state, events and last-code reporting
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_hold        <= '0;
            r_key_state   <= '0;
            r_any_held    <= 1'b0;
            r_event_valid <= 1'b0;
            r_event_key   <= '0;
            r_event_press <= 1'b0;
            r_event_ext   <= 1'b0;
            r_last_code   <= '0;
        end else begin
            r_hold        <= w_hold_nxt;
            r_key_state   <= w_key_state_nxt;
            r_any_held    <= |w_hold_nxt;
            r_event_valid <= w_press || w_release;
            if (w_press || w_release) begin
                r_event_key   <= w_idx;
                r_event_press <= w_press;
            end
            if (w_complete) begin
                r_last_code <= received_data;
                r_event_ext <= w_is_ext;
            end
        end
    end

    assign key_state   = r_key_state;
    assign any_held    = r_any_held;
    assign event_valid = r_event_valid;
    assign event_key   = r_event_key;
    assign event_press = r_event_press;
    assign event_ext   = r_event_ext;
    assign last_code   = r_last_code;

endmodule

// File: tb/tb_ps2_note_keys.sv
// Bench for ps2_note_keys: hold-mode and toggle-mode instances share one
// stimulus stream and are compared each cycle against a sequence-level model.
module tb_ps2_note_keys;

    localparam int unsigned NK = 8;
    localparam int unsigned T  = 16;
    localparam logic [63:0] KC = 64'h423B33342B231B1C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rd;
    logic       rd_en;

    logic [7:0] ks0, ks1, last0, last1;
    logic       any0, any1, ev0, ev1, pr0, pr1, ext0, ext1;
    logic [2:0] key0, key1;

    always #5 clk = ~clk;

    ps2_note_keys #(.NUM_KEYS(NK), .KEY_CODES(KC), .TOGGLE_MODE(1'b0), .TIMEOUT_CYCLES(T)) dut0 (
        .CLOCK_50(clk), .reset(rst), .received_data(rd), .received_data_en(rd_en),
        .key_state(ks0), .any_held(any0), .event_valid(ev0), .event_key(key0),
        .event_press(pr0), .event_ext(ext0), .last_code(last0));

    ps2_note_keys #(.NUM_KEYS(NK), .KEY_CODES(KC), .TOGGLE_MODE(1'b1), .TIMEOUT_CYCLES(T)) dut1 (
        .CLOCK_50(clk), .reset(rst), .received_data(rd), .received_data_en(rd_en),
        .key_state(ks1), .any_held(any1), .event_valid(ev1), .event_key(key1),
        .event_press(pr1), .event_ext(ext1), .last_code(last1));

    int total = 0;
    int bad   = 0;

    // model state: channel map, physical hold, toggle state, pending prefixes
    logic [7:0] keymap [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    bit         m_h [NK];
    bit         m_t [NK];
    bit         m_ext, m_brk;
    int         m_wait;
    bit         e_valid, e_press, e_ext;
    int         e_key;
    logic [7:0] e_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vec_h();
        logic [7:0] v;
        for (int i = 0; i < NK; i++) v[i] = m_h[i];
        return v;
    endfunction

    function automatic logic [7:0] vec_t();
        logic [7:0] v;
        for (int i = 0; i < NK; i++) v[i] = m_t[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_h[i] = 1'b0;
            m_t[i] = 1'b0;
        end
        m_ext = 0; m_brk = 0; m_wait = 0;
        e_valid = 0; e_press = 0; e_ext = 0; e_key = 0; e_last = 8'h00;
    endtask

    // E0 always starts an extended sequence; F0 marks a break and keeps the
    // extension only when it directly follows a lone E0.
    task automatic model_byte(input logic [7:0] b);
        int ch;
        e_valid = 0;
        if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0; m_wait = 0;
        end else if (b == 8'hF0) begin
            m_ext = m_ext && !m_brk; m_brk = 1; m_wait = 0;
        end else begin
            e_last = b;
            e_ext  = m_ext;
            if (!m_ext) begin
                ch = -1;
                for (int i = NK - 1; i >= 0; i--) if (keymap[i] == b) ch = i;
                if (ch >= 0) begin
                    if (!m_brk && !m_h[ch]) begin
                        m_h[ch] = 1; m_t[ch] = !m_t[ch];
                        e_valid = 1; e_key = ch; e_press = 1;
                    end else if (m_brk && m_h[ch]) begin
                        m_h[ch] = 0;
                        e_valid = 1; e_key = ch; e_press = 0;
                    end
                end
            end
            m_ext = 0; m_brk = 0; m_wait = 0;
        end
    endtask

    task automatic model_idle();
        e_valid = 0;
        if (m_ext || m_brk) begin
            m_wait++;
            if (m_wait == T) begin
                m_ext = 0; m_brk = 0; m_wait = 0;
            end
        end
    endtask

    task automatic tick(input bit en, input logic [7:0] b);
        rd    = b;
        rd_en = en;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (en) model_byte(b);
        else    model_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst   = 1'b1;
        rd_en = 1'b0;
        model_reset();
        #1;
        chk("rst_ks0", ks0, 0);     chk("rst_ks1", ks1, 0);
        chk("rst_any0", any0, 0);   chk("rst_ev0", ev0, 0);
        chk("rst_key0", key0, 0);   chk("rst_pr0", pr0, 0);
        chk("rst_ext0", ext0, 0);   chk("rst_last0", last0, 0);
        chk("rst_last1", last1, 0); chk("rst_ev1", ev1, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("cmp_ks0", ks0, vec_h());
            chk("cmp_ks1", ks1, vec_t());
            chk("cmp_any0", any0, |vec_h());
            chk("cmp_any1", any1, |vec_h());
            chk("cmp_ev0", ev0, e_valid);
            chk("cmp_ev1", ev1, e_valid);
            chk("cmp_key0", key0, e_key);
            chk("cmp_key1", key1, e_key);
            chk("cmp_pr0", pr0, e_press);
            chk("cmp_pr1", pr1, e_press);
            chk("cmp_ext0", ext0, e_ext);
            chk("cmp_ext1", ext1, e_ext);
            chk("cmp_last0", last0, e_last);
            chk("cmp_last1", last1, e_last);
        end
    end

    logic [7:0] stream [22] = '{8'h34, 8'hE0, 8'hE0, 8'h34, 8'hF0, 8'hE0, 8'hF0, 8'h34,
                                8'hE0, 8'hF0, 8'hF0, 8'h34, 8'h2B, 8'h2B, 8'hF0, 8'h42,
                                8'h55, 8'hF0, 8'h55, 8'h3B, 8'hF0, 8'h2B};

    initial begin
        rst   = 1'b0;
        rd    = 8'h00;
        rd_en = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        do_reset();

        // first make
        tick(1, 8'h1C);
        chk("mk_ev", ev0, 1);  chk("mk_key", key0, 0); chk("mk_pr", pr0, 1);
        chk("mk_ks", ks0, 8'h01); chk("mk_any", any0, 1); chk("mk_last", last0, 8'h1C);

        // typematic repeats are suppressed
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'h1C);
            chk("typ_ev", ev0, 0);
        end
        tick(1, 8'hF0); tick(1, 8'h1C);
        chk("brk_ev", ev0, 1); chk("brk_pr", pr0, 0); chk("brk_key", key0, 0);
        chk("brk_ks", ks0, 8'h00); chk("brk_any", any0, 0); chk("brk_tog", ks1, 8'h01);

        // multiple channels
        tick(1, 8'h23);
        chk("k2_ks", ks0, 8'h04); chk("k2_key", key0, 2); chk("k2_pr", pr0, 1);
        tick(1, 8'h42);
        chk("k7_ks", ks0, 8'h84); chk("k7_key", key0, 7);
        tick(1, 8'hF0); tick(1, 8'h23);
        chk("k2r_ks", ks0, 8'h80); chk("k2r_key", key0, 2); chk("k2r_pr", pr0, 0);

        // extended codes are reported but never mapped
        tick(1, 8'hE0); tick(1, 8'h1C);
        chk("e0_ev", ev0, 0); chk("e0_ks", ks0, 8'h80);
        chk("e0_last", last0, 8'h1C); chk("e0_ext", ext0, 1);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h1C);
        chk("e0f0_ev", ev0, 0); chk("e0f0_ks", ks0, 8'h80); chk("e0f0_ext", ext0, 1);
        tick(1, 8'h1B);
        chk("k1_ev", ev0, 1); chk("k1_key", key0, 1); chk("k1_ext", ext0, 0);
        chk("k1_ks", ks0, 8'h82);

        // prefix timeout: full window drops the F0
        tick(1, 8'hF0); idle(T); tick(1, 8'h1C);
        chk("to_ev", ev0, 1); chk("to_pr", pr0, 1); chk("to_key", key0, 0);
        chk("to_ks", ks0, 8'h83);
        // one cycle short of the window keeps the F0
        tick(1, 8'hF0); idle(T - 1); tick(1, 8'h1C);
        chk("nto_ev", ev0, 1); chk("nto_pr", pr0, 0); chk("nto_ks", ks0, 8'h82);

        // back-to-back mixed stream with prefix restarts
        foreach (stream[i]) tick(1, stream[i]);
        chk("str_ks", ks0, 8'h42); chk("str_last", last0, 8'h2B);
        idle(2);

        // toggle mode
        do_reset();
        tick(1, 8'h1C);                 chk("tg1", ks1[0], 1);
        tick(1, 8'hF0); tick(1, 8'h1C); chk("tg2", ks1[0], 1);
        tick(1, 8'h1C);                 chk("tg3", ks1[0], 0);
        tick(1, 8'hF0); tick(1, 8'h1C); chk("tg4", ks1[0], 0);

        // reset in the middle of a break sequence
        tick(1, 8'h1C);
        tick(1, 8'hF0);
        do_reset();
        tick(1, 8'h1C);
        chk("post_ev", ev1, 1); chk("post_pr", pr1, 1); chk("post_key", key1, 0);
        chk("post_ks0", ks0, 8'h01); chk("post_ks1", ks1, 8'h01);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_note_keys.md
Name: ps2_note_keys

Overview:
Parametrised PS/2 scancode decoder that sits between PS2_Controller and the note/voice logic of the music studio. It consumes the controller's byte stream, decodes make, break (F0) and extended (E0) sequences, and maps up to NUM_KEYS configured scancodes onto per-key note channels. It keeps a held/toggled state vector for the channels and emits one-cycle press/release events. Supersedes the single-key, last-byte comparison used on the bring-up board.

Parameters:
NUM_KEYS, 8, number of note channels (1..32)
KEY_CODES, 64'h423B33342B231B1C, packed NUM_KEYS*8 make codes; channel i = KEY_CODES[8*i+:8] (default A S D F G H J K)
TOGGLE_MODE, 0, 0 = key_state follows physical hold; 1 = key_state flips on each accepted press
TIMEOUT_CYCLES, 2500000, cycles allowed between prefix byte and final byte (50 ms at 50 MHz)
IDX_W (localparam), max(1,$clog2(NUM_KEYS)), event index width

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
received_data  in  8  byte from PS2_Controller
received_data_en  in  1  one-cycle strobe, received_data valid
key_state  out  NUM_KEYS  per-channel held (or toggled) state
any_held  out  1  OR of physical hold vector (independent of TOGGLE_MODE)
event_valid  out  1  one-cycle pulse per accepted press/release
event_key  out  IDX_W  channel index of the event
event_press  out  1  1 = press, 0 = release; valid with event_valid
event_ext  out  1  final byte of last completed sequence was E0-prefixed
last_code  out  8  last completed non-prefix scancode

Behaviour:
- Reset (async, asserted any time): all outputs 0, FSM to IDLE, timeout counter 0, internal hold vector 0. Reset mid-sequence discards the partial sequence.
- Bytes sampled only on CLOCK_50 edges where received_data_en = 1.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  IDLE: E0->EXT; F0->BRK; other -> complete make, stay IDLE.
  EXT: F0->EXT_BRK; E0->EXT; other -> complete extended make, ->IDLE.
  BRK: F0 or E0 -> restart (F0->BRK, E0->EXT), no event; other -> complete break, ->IDLE.
  EXT_BRK: E0/F0 -> restart as from IDLE; other -> complete extended break, ->IDLE.
- Timeout: counter clears on every accepted byte; counts while FSM != IDLE; on reaching TIMEOUT_CYCLES-1 FSM returns to IDLE, no event.
- On any completion: last_code <= byte, event_ext <= extended flag, same cycle as FSM return (1 cycle after strobe).
- Mapping: only non-extended completions are mapped; channel = lowest i with KEY_CODES[8*i+:8] == byte; unmapped or extended codes update last_code/event_ext only.
- Physical hold vector h: make sets h[i], break clears h[i].
- Typematic suppression: make on channel with h[i]=1 produces no event and no toggle. Break on channel with h[i]=0 produces no event.
- Accepted press: event_valid=1, event_press=1, event_key=i; TOGGLE_MODE=1 flips key_state[i]. Accepted release: event_valid=1, event_press=0.
- TOGGLE_MODE=0: key_state = h. any_held = |h always.
- Latency: event_valid and key_state update registered, exactly 1 cycle after the final byte's strobe; event_valid low otherwise. event_key/event_press hold last values between events.
- Byte strobes on consecutive cycles must be handled back-to-back with no loss.

Test Plan:
- Reset, send 1C -> next cycle event_valid=1, event_key=0, event_press=1, key_state=8'h01, any_held=1, last_code=1C.
- Send 1C,1C,1C (typematic) then F0,1C -> exactly one press and one release event; key_state ends 8'h00, any_held=0.
- Send 23, 42, F0 23 -> key_state 8'h04, then 8'h84, then 8'h80; events key 2 press, key 7 press, key 2 release.
- Send E0 1C, then E0 F0 1C -> no events, key_state unchanged, last_code=1C, event_ext=1; send 1B -> event_key=1, event_ext=0.
- Send F0, wait TIMEOUT_CYCLES idle, send 1C -> treated as make (press event key 0), not break.
- TOGGLE_MODE=1: 1C, F0 1C, 1C, F0 1C -> key_state[0] 1,1,0,0; reset asserted mid "F0" sequence -> all outputs 0 immediately, next 1C is a press.
